// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// Module      : regfile_mp_pkg
// Description : Shared types and default constants for the regfile_mp slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_mp_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int DEPTH_DEF    = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int ZERO_REG_DEF = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_clear_fsm.sv
// ============================================================================
// Module      : regfile_mp_clear_fsm
// Description : Sequential wipe controller; walks every register once and
//               emits a wipe-enable/wipe-address pair plus busy/done status.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wipe_en,
    output logic [ADDR_W-1:0] wipe_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered decodes of the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign wipe_en    = (state_q == CLEAR);
    assign wipe_addr  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Two-write, NUM_RD-read register file with hardwired zero
//               register and sequential wipe. Optional same-cycle write
//               forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load0,
    input  logic [ADDR_W-1:0]        sel_in0,
    input  logic [DATA_W-1:0]        data_in0,
    input  logic                     load1,
    input  logic [ADDR_W-1:0]        sel_in1,
    input  logic [DATA_W-1:0]        data_in1,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     clear_done
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_REG[ADDR_W-1:0];

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wipe_en;
    logic [ADDR_W-1:0] wipe_addr;
    logic              wr0_en;
    logic              wr1_en;

    regfile_mp_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .wipe_en    (wipe_en),
        .wipe_addr  (wipe_addr)
    );

    assign wr0_en = load0 && !clear_busy && (sel_in0 != ZERO_ADDR);
    assign wr1_en = load1 && !clear_busy && (sel_in1 != ZERO_ADDR);

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wipe_en) begin
            regs_d[wipe_addr] = '0;
        end else begin
            if (wr0_en) regs_d[sel_in0] = data_in0;
            if (wr1_en) regs_d[sel_in1] = data_in1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_sel[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = (addr == ZERO_ADDR) ? '0 : regs_q[addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (wr1_en && (sel_in1 == addr)) begin
                data = data_in1;
            end else if (wr0_en && (sel_in0 == addr)) begin
                data = data_in0;
            end
`endif
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

endmodule

`default_nettype wire
